// File: rtl/bcd_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bcd_pkg : shared types and helpers for the sequential binary-to-BCD converter
// Revision: 1.0
// ---------------------------------------------------------------------------
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Decimal digits of 2^bin_w - 1 (floor(bin_w*log10(2)) + 1); 2^n is never a power of ten.
  function automatic int min_digits(input int bin_w);
    longint scaled;
    scaled = longint'(bin_w) * 64'sd30103;
    return int'(scaled / 64'sd100000) + 1;
  endfunction

  function automatic int cnt_width(input int bin_w);
    return $clog2(bin_w + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_seq_converter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bcd_seq_converter_if : start/busy/done handshake plus value and BCD result
// Revision: 1.0
// ---------------------------------------------------------------------------
interface bcd_seq_converter_if #(
  parameter int BIN_W  = 32,
  parameter int DIGITS = 10
);
  logic                  start;
  logic [BIN_W-1:0]      bin;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd;

  modport master (output start, output bin, input busy, input done, input bcd);
  modport slave  (input start, input bin, output busy, output done, output bcd);
endinterface
`default_nettype wire

// File: rtl/bcd_digit_adjust.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bcd_digit_adjust : double-dabble digit correction, adds 3 to digits >= 5
// Revision: 1.0
// ---------------------------------------------------------------------------
module bcd_digit_adjust (
  input  wire logic [3:0] digit_in,
  output logic      [3:0] digit_out
);
  assign digit_out = (digit_in >= 4'd5) ? digit_in + 4'd3 : digit_in;
endmodule
`default_nettype wire

// File: rtl/bcd_seq_converter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bcd_seq_converter : iterative shift-and-add-3 converter, one bit per cycle
// Revision: 1.0
// ---------------------------------------------------------------------------
module bcd_seq_converter
  import bcd_pkg::*;
#(
  parameter int BIN_W  = 32,
  parameter int DIGITS = 10
) (
  input wire logic            clk,
  input wire logic            reset,
  bcd_seq_converter_if.slave  bus
);

  localparam int c_cnt_w = cnt_width(BIN_W);

  generate
    if (DIGITS < min_digits(BIN_W)) begin : g_digits_check
      $error("bcd_seq_converter: DIGITS=%0d too small for BIN_W=%0d", DIGITS, BIN_W);
    end
  endgenerate

  state_t               r_state;
  state_t               w_state_next;
  logic [c_cnt_w-1:0]   r_cnt;
  logic [BIN_W-1:0]     r_bin_work;
  logic [4*DIGITS-1:0]  r_bcd_work;
  logic [4*DIGITS-1:0]  w_bcd_adj;
  logic [4*DIGITS-1:0]  r_bcd;
  logic                 r_done;
  logic                 w_load;
  logic                 w_shift;
  logic                 w_finish;
  logic                 w_busy;

  generate
    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
      bcd_digit_adjust u_adj (
        .digit_in  (r_bcd_work[4*i +: 4]),
        .digit_out (w_bcd_adj[4*i +: 4])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_shift      = 1'b0;
    w_finish     = 1'b0;
    w_busy       = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_load       = 1'b1;
          w_state_next = SHIFT;
        end
      end
      SHIFT: begin
        w_busy  = 1'b1;
        w_shift = 1'b1;
        if (r_cnt == c_cnt_w'(1)) w_state_next = DONE;
      end
      DONE: begin
        w_finish     = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // done is registered so it rises on the same edge that publishes the new bcd.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt      <= '0;
      r_bin_work <= '0;
      r_bcd_work <= '0;
      r_bcd      <= '0;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_load) begin
        r_bin_work <= bus.bin;
        r_bcd_work <= '0;
        r_cnt      <= c_cnt_w'(BIN_W);
      end else if (w_shift) begin
        {r_bcd_work, r_bin_work} <= {w_bcd_adj, r_bin_work} << 1;
        r_cnt                    <= r_cnt - c_cnt_w'(1);
      end
      if (w_finish) r_bcd <= r_bcd_work;
    end
  end

  assign bus.busy = w_busy;
  assign bus.done = r_done;
  assign bus.bcd  = r_bcd;

endmodule
`default_nettype wire

// File: tb/tb_bcd_seq_converter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_bcd_seq_converter : directed self-checking bench for bcd_seq_converter
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_bcd_seq_converter;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  int   checks   = 0;
  int   failures = 0;

  bcd_seq_converter_if #(.BIN_W(32), .DIGITS(10)) bus ();

  bcd_seq_converter #(.BIN_W(32), .DIGITS(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; n counts edges after the accepting edge.
  task automatic convert(input logic [31:0] v, output int latency, output int busy_cycles);
    latency     = -1;
    busy_cycles = 0;
    bus.bin     = v;
    bus.start   = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.busy) busy_cycles++;
      if (bus.done) begin
        latency = n;
        break;
      end
    end
  endtask

  task automatic conv_check(input string tag, input logic [31:0] v, input logic [39:0] exp_bcd);
    int lat;
    int bcnt;
    convert(v, lat, bcnt);
    check({tag, "_latency"}, 64'(lat), 64'd33);
    check({tag, "_busy_cycles"}, 64'(bcnt), 64'd32);
    check({tag, "_bcd"}, 64'(bus.bcd), 64'(exp_bcd));
    @(negedge clk);
    check({tag, "_done_width"}, 64'(bus.done), 64'd0);
    check({tag, "_bcd_hold"}, 64'(bus.bcd), 64'(exp_bcd));
  endtask

  initial begin
    int          lat;
    int          cnt_done;
    int          cnt_busy;
    int          idx;
    int          stable_err;
    int          pos [3];
    logic [39:0] got [3];
    logic [39:0] last;

    bus.start = 1'b0;
    bus.bin   = '0;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_bcd",  64'(bus.bcd),  64'd0);
    reset = 1'b1;
    @(negedge clk);

    // Basic values and boundaries
    conv_check("zero", 32'd0, 40'h0);
    conv_check("v255", 32'd255, 40'h255);
    conv_check("v99", 32'd99, 40'h99);
    conv_check("max", 32'hFFFF_FFFF, 40'h42_9496_7295);
    conv_check("1e9", 32'd1_000_000_000, 40'h10_0000_0000);

    // Start during a conversion is ignored and not queued
    lat       = -1;
    bus.bin   = 32'd1234;
    bus.start = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      bus.start = (n == 9);
      bus.bin   = (n == 9) ? 32'd777 : 32'd1234;
      if (bus.done) begin
        lat = n;
        break;
      end
    end
    bus.start = 1'b0;
    check("ign_latency", 64'(lat), 64'd33);
    check("ign_bcd", 64'(bus.bcd), 64'h1234);
    cnt_done = 0;
    cnt_busy = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) cnt_done++;
      if (bus.busy) cnt_busy++;
    end
    check("ign_extra_done", 64'(cnt_done), 64'd0);
    check("ign_extra_busy", 64'(cnt_busy), 64'd0);

    // Asynchronous reset mid-conversion
    bus.bin   = 32'd5000;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    check("mid_busy_before_rst", 64'(bus.busy), 64'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_busy", 64'(bus.busy), 64'd0);
    check("mid_rst_done", 64'(bus.done), 64'd0);
    check("mid_rst_bcd",  64'(bus.bcd),  64'd0);
    repeat (3) @(negedge clk);
    reset    = 1'b1;
    cnt_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) cnt_done++;
    end
    check("mid_rst_no_done", 64'(cnt_done), 64'd0);
    conv_check("v42", 32'd42, 40'h42);

    // start held high: back-to-back conversions of 7, 8, 9
    for (int k = 0; k < 3; k++) begin
      got[k] = 'x;
      pos[k] = -1;
    end
    last       = 40'h42;
    idx        = 0;
    stable_err = 0;
    bus.bin    = 32'd7;
    bus.start  = 1'b1;
    for (int n = 0; n < 200 && idx < 3; n++) begin
      @(negedge clk);
      if (bus.done) begin
        got[idx] = bus.bcd;
        pos[idx] = n;
        last     = bus.bcd;
        idx++;
        bus.bin  = 32'(7 + idx);
        if (idx == 3) bus.start = 1'b0;
      end else if (bus.bcd !== last) begin
        stable_err++;
      end
    end
    bus.start = 1'b0;
    check("b2b_count", 64'(idx), 64'd3);
    check("b2b_first_latency", 64'(pos[0]), 64'd33);
    check("b2b_bcd0", 64'(got[0]), 64'h7);
    check("b2b_bcd1", 64'(got[1]), 64'h8);
    check("b2b_bcd2", 64'(got[2]), 64'h9);
    check("b2b_period01", 64'(pos[1] - pos[0]), 64'd34);
    check("b2b_period12", 64'(pos[2] - pos[1]), 64'd34);
    check("b2b_bcd_stable", 64'(stable_err), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bcd_seq_converter.md
Name: bcd_seq_converter

Overview:
- Multi-cycle, iterative double-dabble (shift-and-add-3) binary-to-BCD converter.
- Sits downstream of the datapath's register-readout / external-memory-readout ports and upstream of the hexdigit seven-segment decoders.
- Replaces a wide combinational converter with a small sequential one that produces all decimal digits of a 32-bit value.
- Uses a start/busy/done handshake; the last completed result is held stable for the display.

Parameters:
- BIN_W, 32, width of the binary input.
- DIGITS, 10, number of BCD output digits. Must satisfy 10^DIGITS > 2^BIN_W - 1; elaboration-time assertion otherwise.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  request conversion of bin; sampled on rising clk.
- bin  in  BIN_W  binary value; captured only on the cycle start is accepted.
- busy  out  1  high while a conversion is in progress.
- done  out  1  single-cycle pulse; bcd holds the new result from this cycle onward.
- bcd  out  4*DIGITS  packed BCD result; digit i occupies bits [4i+3:4i], digit 0 is least significant.

Behaviour:
- Reset (reset=0, async): state=IDLE, busy=0, done=0, bcd=0, shift counter=0, working registers=0. Takes effect immediately, including mid-conversion; any in-flight conversion is discarded and no done is produced.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - If start=1, load working binary reg with bin, clear working BCD reg, set counter=BIN_W, go to SHIFT.
  - busy=0 in IDLE.
- SHIFT (busy=1), one iteration per cycle:
  - For every working BCD digit >= 5, add 3 (4-bit, no carry out of the digit).
  - Shift {bcd_work, bin_work} left by 1.
  - Decrement counter. When counter reaches 0 after the shift, go to DONE.
- DONE (busy=0, done=1 for exactly this cycle): copy working BCD reg to the bcd output register, go to IDLE.
- Latency: start accepted at edge 0 -> SHIFT occupies edges 1..BIN_W -> done=1 and bcd updated after edge BIN_W+1 (33 cycles for BIN_W=32). Next start can be accepted at edge BIN_W+2.
- start while busy=1 or in DONE: ignored, not queued. bin changes during a conversion have no effect.
- start held high continuously: a new conversion starts on every IDLE cycle, giving back-to-back conversions with period BIN_W+2.
- bcd changes only in DONE (or at reset); it is glitch-free for the downstream hexdigit decoders.
- Value 0 produces all-zero digits. Maximum value 2^BIN_W-1 (4294967295) must convert exactly with DIGITS=10; no overflow flag is needed given the parameter check.
- Top digits beyond the value's magnitude read 0 (no blanking in this block).

Decomposition:
- Package bcd_pkg:
  - state enum {IDLE, SHIFT, DONE}.
  - Constant function min_digits(bin_w) used by the DIGITS assertion.
  - Counter width = $clog2(BIN_W+1).
- Sub-module bcd_digit_adjust: combinational, 4-bit in / 4-bit out, adds 3 when the input is >= 5. Instantiated DIGITS times via generate.
- Everything else (FSM, counter, shift registers, output register) lives in bcd_seq_converter.

Test Plan:
- Reset, then start with bin=0 -> done pulses exactly 33 cycles after start accepted; bcd=0; busy high for 32 cycles.
- bin=255 -> bcd[11:0]=0x255, upper digits 0. bin=99 -> bcd[7:0]=0x99. done is one cycle wide in each case.
- bin=32'hFFFF_FFFF -> bcd=40'h42_9496_7295 exactly; bin=1_000_000_000 -> bcd=40'h10_0000_0000.
- Convert 1234, then pulse start with bin=777 at cycle 10 of the conversion -> ignored; result is 0x1234, no second done.
- Assert reset=0 at cycle 15 of a conversion of 5000 -> busy=0 and bcd=0 immediately, no done. Release reset and convert 42 -> bcd=0x42.
- Hold start=1 with bin stepping 7, 8, 9 each accept -> done every 34 cycles with bcd=7, 8, 9 in order; bcd stable between done pulses.
